// File: rtl/tlb_op_ctrl.sv
// TLB management sequencer: runs TLBP/TLBR/TLBWI/TLBWR against a synchronous-read TLB array
// and hands TLBR/TLBP results back to CP0, stalling the pipeline while busy.
module tlb_op_ctrl #(
    parameter int TLB_ENTRY_NUM = 16,
    parameter int IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    input  logic [1:0]       op_i,
    input  logic             flush_i,
    input  logic [31:0]      index_i,
    input  logic [31:0]      random_i,
    input  logic [31:0]      entryhi_i,
    input  logic [31:0]      entrylo0_i,
    input  logic [31:0]      entrylo1_i,
    input  logic [31:0]      pagemask_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             tlb_re_o,
    output logic [IDX_W-1:0] tlb_raddr_o,
    input  logic [18:0]      tlb_rvpn2_i,
    input  logic [7:0]       tlb_rasid_i,
    input  logic [15:0]      tlb_rmask_i,
    input  logic             tlb_rg_i,
    input  logic [31:0]      tlb_rlo0_i,
    input  logic [31:0]      tlb_rlo1_i,
    output logic             tlb_we_o,
    output logic [IDX_W-1:0] tlb_waddr_o,
    output logic [18:0]      tlb_wvpn2_o,
    output logic [7:0]       tlb_wasid_o,
    output logic [15:0]      tlb_wmask_o,
    output logic             tlb_wg_o,
    output logic [31:0]      tlb_wlo0_o,
    output logic [31:0]      tlb_wlo1_o,
    output logic             tlbr_op_o,
    output logic             tlbp_op_o,
    output logic [31:0]      entryhi_o,
    output logic [31:0]      entrylo0_o,
    output logic [31:0]      entrylo1_o,
    output logic [31:0]      index_o,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        PROBE = 2'd3
    } state_t;

    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(TLB_ENTRY_NUM);
    localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

    state_t           state;
    logic [18:0]      op_vpn2;
    logic [7:0]       op_asid;
    logic [15:0]      op_mask;
    logic [31:0]      op_lo0;
    logic [31:0]      op_lo1;
    logic [IDX_W-1:0] op_addr;
    // In READ: 0 = issue read, 1 = writeback. In PROBE: number of reads issued so far.
    logic [IDX_W:0]   cnt;

    logic [18:0]      cmp_mask;
    logic             probe_hit;
    logic             probe_end;
    logic [IDX_W:0]   hit_idx;
    logic             unused_bits;

    assign unused_bits = ^{entryhi_i[12:8], pagemask_i[31:29], pagemask_i[12:0],
                           index_i[31:IDX_W], random_i[31:IDX_W]};

    // Compare stage looks at the entry whose read was issued last cycle (cnt-1).
    assign cmp_mask  = {3'b0, tlb_rmask_i};
    assign probe_hit = (cnt != '0)
                     && ((tlb_rvpn2_i & ~cmp_mask) == (op_vpn2 & ~cmp_mask))
                     && (tlb_rg_i || (tlb_rasid_i == op_asid));
    assign probe_end = probe_hit || (cnt == LAST);
    assign hit_idx   = cnt - ONE;

    assign fsm_state = rst ? 2'd0 : state;

    always_comb begin
        stall_o     = 1'b0;
        done_o      = 1'b0;
        tlb_re_o    = 1'b0;
        tlb_raddr_o = '0;
        tlb_we_o    = 1'b0;
        tlb_waddr_o = '0;
        tlb_wvpn2_o = '0;
        tlb_wasid_o = '0;
        tlb_wmask_o = '0;
        tlb_wg_o    = 1'b0;
        tlb_wlo0_o  = '0;
        tlb_wlo1_o  = '0;
        tlbr_op_o   = 1'b0;
        tlbp_op_o   = 1'b0;
        entryhi_o   = '0;
        entrylo0_o  = '0;
        entrylo1_o  = '0;
        index_o     = '0;
        if (!rst) begin
            case (state)
                IDLE: stall_o = op_valid_i & ~flush_i;
                WRITE: if (!flush_i) begin
                    tlb_we_o    = 1'b1;
                    done_o      = 1'b1;
                    tlb_waddr_o = op_addr;
                    tlb_wvpn2_o = op_vpn2;
                    tlb_wasid_o = op_asid;
                    tlb_wmask_o = op_mask;
                    tlb_wg_o    = op_lo0[0] & op_lo1[0];
                    tlb_wlo0_o  = op_lo0;
                    tlb_wlo1_o  = op_lo1;
                end
                READ: if (!flush_i) begin
                    if (cnt == '0) begin
                        tlb_re_o    = 1'b1;
                        tlb_raddr_o = op_addr;
                        stall_o     = 1'b1;
                    end else begin
                        done_o     = 1'b1;
                        tlbr_op_o  = 1'b1;
                        entryhi_o  = {tlb_rvpn2_i, 5'b0, tlb_rasid_i};
                        entrylo0_o = {tlb_rlo0_i[31:1], tlb_rg_i};
                        entrylo1_o = {tlb_rlo1_i[31:1], tlb_rg_i};
                    end
                end
                PROBE: if (!flush_i) begin
                    if (probe_end) begin
                        done_o    = 1'b1;
                        tlbp_op_o = 1'b1;
                        index_o   = probe_hit ? 32'(hit_idx) : 32'h8000_0000;
                    end else begin
                        tlb_re_o    = 1'b1;
                        tlb_raddr_o = cnt[IDX_W-1:0];
                        stall_o     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_vpn2 <= '0;
            op_asid <= '0;
            op_mask <= '0;
            op_lo0  <= '0;
            op_lo1  <= '0;
            op_addr <= '0;
        end else begin
            case (state)
                IDLE: if (op_valid_i && !flush_i) begin
                    op_vpn2 <= entryhi_i[31:13];
                    op_asid <= entryhi_i[7:0];
                    op_mask <= pagemask_i[28:13];
                    op_lo0  <= entrylo0_i;
                    op_lo1  <= entrylo1_i;
                    op_addr <= (op_i == 2'b11) ? random_i[IDX_W-1:0] : index_i[IDX_W-1:0];
                    cnt     <= '0;
                    case (op_i)
                        2'b00:   state <= PROBE;
                        2'b01:   state <= READ;
                        default: state <= WRITE;
                    endcase
                end
                WRITE: state <= IDLE;
                READ: begin
                    if (flush_i || cnt != '0) state <= IDLE;
                    else cnt <= ONE;
                end
                PROBE: begin
                    if (flush_i || probe_end) state <= IDLE;
                    else cnt <= cnt + ONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: acts as the TLB array, predicts every output cycle from an
// op-level model of the TLB contents, and pins the model with directed literal checks.
module tb_tlb_op_ctrl;
    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tb_init = 1'b1;
    logic          op_valid_i = 1'b0;
    logic [1:0]    op_i = '0;
    logic          flush_i = 1'b0;
    logic [31:0]   index_i = '0, random_i = '0, entryhi_i = '0;
    logic [31:0]   entrylo0_i = '0, entrylo1_i = '0, pagemask_i = '0;
    logic          stall_o, done_o, tlb_re_o, tlb_we_o, tlb_wg_o, tlbr_op_o, tlbp_op_o;
    logic [IW-1:0] tlb_raddr_o, tlb_waddr_o;
    logic [18:0]   tlb_rvpn2_i = '0, tlb_wvpn2_o;
    logic [7:0]    tlb_rasid_i = '0, tlb_wasid_o;
    logic [15:0]   tlb_rmask_i = '0, tlb_wmask_o;
    logic          tlb_rg_i = 1'b0;
    logic [31:0]   tlb_rlo0_i = '0, tlb_rlo1_i = '0, tlb_wlo0_o, tlb_wlo1_o;
    logic [31:0]   entryhi_o, entrylo0_o, entrylo1_o, index_o;
    logic [1:0]    fsm_state;

    typedef struct packed {
        logic        stall, done, re;
        logic [3:0]  raddr;
        logic        we;
        logic [3:0]  waddr;
        logic [18:0] wvpn2;
        logic [7:0]  wasid;
        logic [15:0] wmask;
        logic        wg;
        logic [31:0] wlo0, wlo1;
        logic        tlbr, tlbp;
        logic [31:0] ehi, elo0, elo1, idx;
    } out_t;

    out_t act;
    assign act = {stall_o, done_o, tlb_re_o, tlb_raddr_o, tlb_we_o, tlb_waddr_o, tlb_wvpn2_o,
                  tlb_wasid_o, tlb_wmask_o, tlb_wg_o, tlb_wlo0_o, tlb_wlo1_o, tlbr_op_o,
                  tlbp_op_o, entryhi_o, entrylo0_o, entrylo1_o, index_o};

    tlb_op_ctrl #(.TLB_ENTRY_NUM(N)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i), .flush_i(flush_i),
        .index_i(index_i), .random_i(random_i), .entryhi_i(entryhi_i),
        .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i), .pagemask_i(pagemask_i),
        .stall_o(stall_o), .done_o(done_o), .tlb_re_o(tlb_re_o), .tlb_raddr_o(tlb_raddr_o),
        .tlb_rvpn2_i(tlb_rvpn2_i), .tlb_rasid_i(tlb_rasid_i), .tlb_rmask_i(tlb_rmask_i),
        .tlb_rg_i(tlb_rg_i), .tlb_rlo0_i(tlb_rlo0_i), .tlb_rlo1_i(tlb_rlo1_i),
        .tlb_we_o(tlb_we_o), .tlb_waddr_o(tlb_waddr_o), .tlb_wvpn2_o(tlb_wvpn2_o),
        .tlb_wasid_o(tlb_wasid_o), .tlb_wmask_o(tlb_wmask_o), .tlb_wg_o(tlb_wg_o),
        .tlb_wlo0_o(tlb_wlo0_o), .tlb_wlo1_o(tlb_wlo1_o), .tlbr_op_o(tlbr_op_o),
        .tlbp_op_o(tlbp_op_o), .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o),
        .entrylo1_o(entrylo1_o), .index_o(index_o), .fsm_state(fsm_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // TLB array the DUT talks to
    logic [18:0] s_vpn2[N];
    logic [7:0]  s_asid[N];
    logic [15:0] s_mask[N];
    logic        s_g[N];
    logic [31:0] s_lo0[N], s_lo1[N];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < N; i++) begin
                s_vpn2[i] <= 19'h70000 + 19'(i);
                s_asid[i] <= 8'hA0 + 8'(i);
                s_mask[i] <= '0;
                s_g[i]    <= 1'b0;
                s_lo0[i]  <= 32'h1000_0000 + 32'(i * 16);
                s_lo1[i]  <= 32'h2000_0000 + 32'(i * 16);
            end
        end else begin
            if (tlb_re_o) begin
                tlb_rvpn2_i <= s_vpn2[tlb_raddr_o];
                tlb_rasid_i <= s_asid[tlb_raddr_o];
                tlb_rmask_i <= s_mask[tlb_raddr_o];
                tlb_rg_i    <= s_g[tlb_raddr_o];
                tlb_rlo0_i  <= s_lo0[tlb_raddr_o];
                tlb_rlo1_i  <= s_lo1[tlb_raddr_o];
            end
            if (tlb_we_o) begin
                s_vpn2[tlb_waddr_o] <= tlb_wvpn2_o;
                s_asid[tlb_waddr_o] <= tlb_wasid_o;
                s_mask[tlb_waddr_o] <= tlb_wmask_o;
                s_g[tlb_waddr_o]    <= tlb_wg_o;
                s_lo0[tlb_waddr_o]  <= tlb_wlo0_o;
                s_lo1[tlb_waddr_o]  <= tlb_wlo1_o;
            end
        end
    end

    // Reference model of TLB contents
    logic [18:0] m_vpn2[N];
    logic [7:0]  m_asid[N];
    logic [15:0] m_mask[N];
    logic        m_g[N];
    logic [31:0] m_lo0[N], m_lo1[N];

    // Scoreboard
    out_t exp_q[$];
    int   cyc_q[$];
    int   checks = 0;
    int   passes = 0;
    int   done_cyc;
    out_t done_out;

    initial begin
        out_t e;
        int   c;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                checks++;
                if (act === e) passes++;
                else $display("FAIL outputs cyc%0d got=%h exp=%h", c, act, e);
                if (act.done === 1'b1) begin
                    done_cyc = c;
                    done_out = act;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    function automatic int probe_model(input logic [18:0] vp, input logic [7:0] as);
        for (int i = 0; i < N; i++) begin
            logic [18:0] msk;
            msk = {3'b0, m_mask[i]};
            if (((m_vpn2[i] & ~msk) == (vp & ~msk)) && (m_g[i] || m_asid[i] == as)) return i;
        end
        return -1;
    endfunction

    // Driver: holds the op for its predicted duration and queues the expected outputs.
    task automatic run_op(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] rnd,
                          input logic [31:0] ehi, input logic [31:0] lo0, input logic [31:0] lo1,
                          input logic [31:0] pm, input int flush_at, input int rst_at);
        int            lat, hit;
        bit            aborted;
        out_t          e;
        logic [IW-1:0] a;
        a = (op == 2'b11) ? rnd[IW-1:0] : idx[IW-1:0];
        hit = (op == 2'b00) ? probe_model(ehi[31:13], ehi[7:0]) : -1;
        lat = op[1] ? 1 : (op == 2'b01) ? 2 : (hit >= 0 ? hit + 2 : N + 1);
        done_cyc = -1;
        done_out = '0;
        aborted = 1'b0;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            op_valid_i = 1'b1; op_i = op; index_i = idx; random_i = rnd; entryhi_i = ehi;
            entrylo0_i = lo0; entrylo1_i = lo1; pagemask_i = pm;
            flush_i = (c == flush_at);
            rst = (c == rst_at);
            e = '0;
            if (c == flush_at || c == rst_at) aborted = 1'b1;
            else if (c == 0) e.stall = 1'b1;
            else if (op[1]) begin
                e.done = 1'b1; e.we = 1'b1; e.waddr = a; e.wvpn2 = ehi[31:13];
                e.wasid = ehi[7:0]; e.wmask = pm[28:13]; e.wg = lo0[0] & lo1[0];
                e.wlo0 = lo0; e.wlo1 = lo1;
            end else if (op == 2'b01) begin
                if (c == 1) begin
                    e.stall = 1'b1; e.re = 1'b1; e.raddr = a;
                end else begin
                    e.done = 1'b1; e.tlbr = 1'b1;
                    e.ehi  = {m_vpn2[a], 5'b0, m_asid[a]};
                    e.elo0 = {m_lo0[a][31:1], m_g[a]};
                    e.elo1 = {m_lo1[a][31:1], m_g[a]};
                end
            end else begin
                if (c < lat) begin
                    e.stall = 1'b1; e.re = 1'b1; e.raddr = IW'(c - 1);
                end else begin
                    e.done = 1'b1; e.tlbp = 1'b1;
                    e.idx = (hit >= 0) ? 32'(hit) : 32'h8000_0000;
                end
            end
            exp_q.push_back(e);
            cyc_q.push_back(c);
            if (aborted) break;
        end
        @(negedge clk);
        op_valid_i = 1'b0; flush_i = 1'b0; rst = 1'b0;
        exp_q.push_back('0);
        cyc_q.push_back(lat + 1);
        if (!aborted && op[1]) begin
            m_vpn2[a] = ehi[31:13]; m_asid[a] = ehi[7:0]; m_mask[a] = pm[28:13];
            m_g[a] = lo0[0] & lo1[0]; m_lo0[a] = lo0; m_lo1[a] = lo1;
        end
        #3;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_vpn2[i] = 19'h70000 + 19'(i);
            m_asid[i] = 8'hA0 + 8'(i);
            m_mask[i] = '0;
            m_g[i]    = 1'b0;
            m_lo0[i]  = 32'h1000_0000 + 32'(i * 16);
            m_lo1[i]  = 32'h2000_0000 + 32'(i * 16);
        end
        // Reset with an op pending: everything must stay 0
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst = 1'b1; op_valid_i = 1'b1; op_i = 2'b00;
            exp_q.push_back('0);
            cyc_q.push_back(c);
        end
        @(negedge clk);
        rst = 1'b0; op_valid_i = 1'b0; tb_init = 1'b0;
        exp_q.push_back('0);
        cyc_q.push_back(0);
        #3;

        // Directed cases with hand-computed values
        run_op(2'b10, 5, 0, 32'h0040_2012, 32'h0000_0003, 32'h0000_0041, 0, -1, -1);
        chk("wi_latency", 32'(done_cyc), 1);
        chk("wi_waddr", 32'(done_out.waddr), 5);
        chk("wi_vpn2", 32'(done_out.wvpn2), 32'h201);
        chk("wi_asid", 32'(done_out.wasid), 32'h12);
        chk("wi_g", 32'(done_out.wg), 1);

        run_op(2'b01, 5, 0, 0, 0, 0, 0, -1, -1);
        chk("tlbr_latency", 32'(done_cyc), 2);
        chk("tlbr_entryhi", done_out.ehi, 32'h0040_2012);
        chk("tlbr_lo0", done_out.elo0, 32'h0000_0003);
        chk("tlbr_lo1", done_out.elo1, 32'h0000_0041);

        run_op(2'b10, 3, 0, 32'h0060_0055, 32'h2, 32'h4, 0, -1, -1);
        run_op(2'b10, 7, 0, 32'h0060_0055, 32'h2, 32'h4, 0, -1, -1);
        run_op(2'b00, 0, 0, 32'h0060_0055, 0, 0, 0, -1, -1);
        chk("tlbp_hit_latency", 32'(done_cyc), 5);
        chk("tlbp_hit_index", done_out.idx, 3);
        chk("tlbp_hit_re", 32'(done_out.re), 0);

        run_op(2'b00, 0, 0, 32'h0060_0056, 0, 0, 0, -1, -1);
        chk("tlbp_asid_miss_latency", 32'(done_cyc), 17);
        chk("tlbp_asid_miss_index", done_out.idx, 32'h8000_0000);
        run_op(2'b00, 0, 0, 32'h1234_5077, 0, 0, 0, -1, -1);
        chk("tlbp_miss_index", done_out.idx, 32'h8000_0000);

        run_op(2'b10, 9, 0, {19'h12340, 5'b0, 8'h33}, 32'h2, 32'h2, 32'h1FFF_E000, -1, -1);
        run_op(2'b00, 0, 0, {19'h1ABCD, 5'b0, 8'h33}, 0, 0, 0, -1, -1);
        chk("tlbp_mask_index", done_out.idx, 9);
        chk("tlbp_mask_latency", 32'(done_cyc), 11);

        run_op(2'b10, 12, 0, {19'h04444, 5'b0, 8'h01}, 32'h1, 32'h1, 0, -1, -1);
        run_op(2'b00, 0, 0, {19'h04444, 5'b0, 8'h99}, 0, 0, 0, -1, -1);
        chk("tlbp_global_index", done_out.idx, 12);

        // Aborts: flushed TLBWR must leave entry 2 untouched
        run_op(2'b11, 0, 2, 32'hFFFF_FFFF, 32'h5, 32'h7, 0, 1, -1);
        chk("flush_wr_done", 32'(done_cyc), 32'hFFFF_FFFF);
        run_op(2'b01, 2, 0, 0, 0, 0, 0, -1, -1);
        chk("flush_wr_untouched", done_out.ehi, {19'h70002, 5'b0, 8'hA2});
        run_op(2'b00, 0, 0, 32'h0060_0055, 0, 0, 0, 4, -1);
        chk("flush_probe_done", 32'(done_cyc), 32'hFFFF_FFFF);
        run_op(2'b00, 0, 0, 32'h0060_0056, 0, 0, 0, -1, 6);
        chk("rst_probe_done", 32'(done_cyc), 32'hFFFF_FFFF);
        run_op(2'b00, 0, 0, 32'h0060_0055, 0, 0, 0, 0, -1);
        chk("flush_accept_done", 32'(done_cyc), 32'hFFFF_FFFF);

        // Randomized ops
        for (int n = 0; n < 200; n++) begin
            logic [1:0]  op;
            logic [31:0] ehi, pm;
            int          k, fl, rs;
            op  = 2'($urandom_range(0, 3));
            ehi = $urandom;
            if (op == 2'b00 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, N - 1);
                ehi = {m_vpn2[k], ehi[12:8], ($urandom_range(0, 1) == 1) ? m_asid[k] : ehi[7:0]};
            end
            pm = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h1FFF_E000) : 32'h0;
            fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
            rs = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 3) : -1;
            run_op(op, $urandom, $urandom, ehi, $urandom, $urandom, pm, fl, rs);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle sequencer for the MIPS TLB management instructions TLBP, TLBR, TLBWI and TLBWR. It sits between the MEM stage, the CP0 register file and the TLB storage array. It takes CP0 Index/Random/EntryHi/EntryLo0/EntryLo1/PageMask as operands, drives the TLB's synchronous read port and write port, and returns TLBR/TLBP results to CP0 through its tlbr/tlbp writeback inputs. It stalls the pipeline while an operation is in flight.

## Interface
- TLB_ENTRY_NUM, 16, number of TLB entries; power of two, 2..32
- IDX_W, $clog2(TLB_ENTRY_NUM), index width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- op_valid_i  in  1  TLB instruction present in MEM; held while stall_o=1
- op_i  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- flush_i  in  1  pipeline flush; aborts the current operation
- index_i, random_i, entryhi_i, entrylo0_i, entrylo1_i, pagemask_i  in  32 each  CP0 operand registers
- stall_o  out  1  pipeline stall request
- done_o  out  1  one-cycle completion pulse
- tlb_re_o  out  1  TLB read enable
- tlb_raddr_o  out  IDX_W  TLB read address
- tlb_rvpn2_i  in  19  TLB read data, 1 cycle after tlb_re_o
- tlb_rasid_i  in  8  TLB read data, 1 cycle after tlb_re_o
- tlb_rmask_i  in  16  TLB read data, 1 cycle after tlb_re_o
- tlb_rg_i  in  1  TLB read data, 1 cycle after tlb_re_o
- tlb_rlo0_i, tlb_rlo1_i  in  32 each  TLB read data, 1 cycle after tlb_re_o
- tlb_we_o  out  1  TLB write enable
- tlb_waddr_o  out  IDX_W  TLB write address
- tlb_wvpn2_o  out  19  TLB write data
- tlb_wasid_o  out  8  TLB write data
- tlb_wmask_o  out  16  TLB write data
- tlb_wg_o  out  1  TLB write data
- tlb_wlo0_o, tlb_wlo1_o  out  32 each  TLB write data
- tlbr_op_o  out  1  CP0 writeback strobe for TLBR
- tlbp_op_o  out  1  CP0 writeback strobe for TLBP
- entryhi_o, entrylo0_o, entrylo1_o, index_o  out  32 each  CP0 writeback data

## Operation
- FSM states: IDLE, WRITE, READ, PROBE. From IDLE, op_valid_i=1 and flush_i=0 accepts the op. On accept:
  - All operands are latched.
  - The write address is latched: index_i[IDX_W-1:0] for TLBWI, random_i[IDX_W-1:0] for TLBWR.
  - The FSM moves to WRITE (TLBWI/TLBWR), READ (TLBR) or PROBE (TLBP).
- Field mapping:
  - vpn2 = entryhi[31:13], asid = entryhi[7:0], mask = pagemask[28:13].
  - Write data: g = entrylo0[0] & entrylo1[0]. Lo data is written unmodified.
- WRITE: tlb_we_o=1 with the latched address and data for one cycle. done_o=1 in the same cycle. Next state IDLE.
- READ:
  - First cycle: tlb_re_o=1, addr = latched index.
  - Second cycle: tlbr_op_o=1 and done_o=1, then IDLE.
  - Writeback: entryhi_o = {vpn2, 5'b0, asid}. entrylo0_o and entrylo1_o are the read data with bit 0 replaced by tlb_rg_i.
- PROBE: serial scan with a counter.
  - Read counter r issues entry r per cycle, from 0 to N-1.
  - Compare stage checks the entry read in the previous cycle.
  - Match: (tlb_rvpn2_i & ~{3'b0, tlb_rmask_i}) == (vpn2 & ~{3'b0, tlb_rmask_i}), AND (tlb_rg_i | tlb_rasid_i == asid).
  - On the first match at entry m: tlbp_op_o=1, done_o=1, index_o = m zero-extended. tlb_re_o is 0 in that cycle. The lowest matching index wins.
  - No match after entry N-1 is compared: index_o = 32'h8000_0000, tlbp_op_o=1, done_o=1.
  - The FSM then returns to IDLE.
- stall_o = (IDLE & op_valid_i & ~flush_i) | (state≠IDLE & ~done_o). The pipeline advances in the done cycle.
- flush_i in any non-IDLE state forces tlb_we_o, tlb_re_o, tlbr_op_o, tlbp_op_o, done_o and stall_o to 0 in that cycle. The FSM then returns to IDLE; the TLB is not written and CP0 is not updated.
- Writeback data outputs are 0 when their strobe is low.

## Timing
- Cycle 0 is the accept cycle. Under reset, state=IDLE and every output is 0.
- TLBWI/TLBWR: write and done in cycle 1. Latency 1.
- TLBR: read issued in cycle 1, writeback and done in cycle 2.
- TLBP, hit at entry m: reads in cycles 1..m+1, done in cycle m+2.
- TLBP, miss: reads in cycles 1..N, done in cycle N+1.
- Earliest back-to-back accept is the cycle after done_o.
- rst during any state returns the FSM to IDLE on the next edge with no write issued.

## Test plan
- TLBWI with index=5, entryhi=0x0040_2012, lo0=0x…3, lo1=0x…1 -> cycle 1: tlb_we_o=1, waddr=5, vpn2=0x201, asid=0x12, g=1, done_o=1. stall_o high only in cycle 0.
- TLBR with index=5 after the write above -> cycle 2: tlbr_op_o=1, entryhi_o=0x0040_2012, entrylo0_o[0]=1, entrylo1_o[0]=1.
- TLBP hitting entries 3 and 7 (same vpn2/asid) -> done in cycle 5, index_o=3, tlb_re_o=0 in cycle 5.
- TLBP miss, and TLBP where the only match is ASID-mismatched with g=0 -> done in cycle 17 (N=16), index_o=0x8000_0000.
- TLBP hit through mask=0xFFFF with differing low vpn2 bits; TLBP hit via g=1 with different asid -> hit reported.
- flush_i in cycle 1 of TLBWR and in cycle 4 of TLBP -> no tlb_we_o, no tlbp_op_o, IDLE next cycle. rst mid-PROBE -> all outputs 0.
